// File: rtl/lift53_fwd_line_if.sv
// rtl/lift53_fwd_line_if.sv - sample/coefficient stream bundle for the forward 5/3 lifting line engine
//
// Purpose: groups the input sample stream, the output coefficient stream and
// the framing error flag of lift53_fwd_line.
// Signals:
//   in_valid/in_ready/in_data/in_last      raw sample stream (x[k], in_last marks x[L-1])
//   out_valid/out_ready/out_s/out_d        coefficient pair stream (s[n], d[n])
//   out_idx/out_last                       pair index n, last pair of the line
//   line_err                               one-cycle framing mismatch pulse
// Modports: master = producer/consumer around the block, slave = the block.
interface lift53_fwd_line_if #(
    parameter int WIDTH    = 10,
    parameter int LINE_LEN = 8
);
    localparam int IDX_W = $clog2(LINE_LEN / 2);

    logic                    in_valid;
    logic                    in_ready;
    logic signed [WIDTH-1:0] in_data;
    logic                    in_last;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [WIDTH+1:0] out_s;
    logic signed [WIDTH+1:0] out_d;
    logic [IDX_W-1:0]        out_idx;
    logic                    out_last;
    logic                    line_err;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_s, out_d, out_idx, out_last, line_err
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_s, out_d, out_idx, out_last, line_err
    );
endinterface

// File: rtl/lift53_fwd_line.sv
// rtl/lift53_fwd_line.sv - streaming forward LeGall 5/3 lifting engine for one image line
//
// Purpose: accepts LINE_LEN raw samples per line and emits LINE_LEN/2 (s, d)
// pairs with symmetric extension at both line ends.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   lift53_fwd_line_if.slave (sample input stream, pair output stream, line_err)
module lift53_fwd_line #(
    parameter int WIDTH    = 10,
    parameter int LINE_LEN = 8
) (
    input logic              clk,
    input logic              rst,
    lift53_fwd_line_if.slave bus
);
    localparam int IDX_W = $clog2(LINE_LEN / 2);
    localparam int K_W   = $clog2(LINE_LEN);
    localparam int WS    = WIDTH + 2;
    localparam int W3    = WIDTH + 3;

    localparam logic [K_W-1:0]       K_LAST   = K_W'(LINE_LEN - 1);
    localparam logic [K_W-1:0]       K_FIRSTP = K_W'(2);
    localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(LINE_LEN / 2 - 1);
    localparam logic signed [W3-1:0] ROUND    = W3'(2);

    if ((LINE_LEN % 2) != 0 || LINE_LEN < 4) begin : g_bad_line_len
        $error("lift53_fwd_line: LINE_LEN must be even and >= 4");
    end

    typedef enum logic [1:0] {
        ST_FIRST,
        ST_ODD,
        ST_EVEN
    } state_t;

    state_t                  state;
    logic [K_W-1:0]          k;
    logic signed [WIDTH-1:0] e;
    logic signed [WIDTH-1:0] o;
    logic signed [WS-1:0]    dp;

    logic                    acc;
    logic signed [W3-1:0]    x_w;
    logic signed [W3-1:0]    e_w;
    logic signed [W3-1:0]    o_w;
    logic signed [W3-1:0]    pair_sum;
    logic signed [W3-1:0]    upd_sum;
    logic signed [WS-1:0]    d_n;
    logic signed [WS-1:0]    d_left;
    logic signed [WS-1:0]    s_n;

    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    assign acc          = bus.in_valid && bus.in_ready;

    assign x_w = {{3{bus.in_data[WIDTH-1]}}, bus.in_data};
    assign e_w = {{3{e[WIDTH-1]}}, e};
    assign o_w = {{3{o[WIDTH-1]}}, o};

    // In ODD the incoming sample is x[L-1]; the right mirror x[L] = x[L-2] = e
    // collapses the predict term to e itself. In EVEN the incoming sample is
    // x[2n+2] and the stored odd sample is x[2n+1].
    always_comb begin
        pair_sum = '0;
        if (state == ST_ODD) begin
            d_n = WS'(x_w - e_w);
        end else begin
            pair_sum = e_w + x_w;
            d_n      = WS'(o_w - (pair_sum >>> 1));
        end
        // Left mirror: the first pair of a line (k == 2 in EVEN) reuses its own d.
        d_left  = (state == ST_EVEN && k == K_FIRSTP) ? d_n : dp;
        upd_sum = {d_left[WS-1], d_left} + {d_n[WS-1], d_n} + ROUND;
        s_n     = WS'(e_w + (upd_sum >>> 2));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_FIRST;
            k             <= '0;
            e             <= '0;
            o             <= '0;
            dp            <= '0;
            bus.out_valid <= 1'b0;
            bus.out_s     <= '0;
            bus.out_d     <= '0;
            bus.out_idx   <= '0;
            bus.out_last  <= 1'b0;
            bus.line_err  <= 1'b0;
        end else begin
            bus.line_err <= 1'b0;
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (acc) begin
                k            <= k + 1'b1;
                bus.line_err <= (bus.in_last != (k == K_LAST));
                case (state)
                    ST_FIRST: begin
                        e     <= bus.in_data;
                        state <= ST_ODD;
                    end
                    ST_ODD: begin
                        o <= bus.in_data;
                        if (k == K_LAST) begin
                            bus.out_valid <= 1'b1;
                            bus.out_s     <= s_n;
                            bus.out_d     <= d_n;
                            bus.out_idx   <= IDX_LAST;
                            bus.out_last  <= 1'b1;
                            k             <= '0;
                            state         <= ST_FIRST;
                        end else begin
                            state <= ST_EVEN;
                        end
                    end
                    ST_EVEN: begin
                        // k = 2n+2 here, so k/2 - 1 is the pair index n.
                        bus.out_valid <= 1'b1;
                        bus.out_s     <= s_n;
                        bus.out_d     <= d_n;
                        bus.out_idx   <= k[K_W-1:1] - IDX_W'(1);
                        bus.out_last  <= 1'b0;
                        dp            <= d_n;
                        e             <= bus.in_data;
                        state         <= ST_ODD;
                    end
                    default: state <= ST_FIRST;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lift53_fwd_line.sv
// tb/tb_lift53_fwd_line.sv - self-checking bench for lift53_fwd_line
module tb_lift53_fwd_line;
    localparam int W  = 10;
    localparam int L  = 8;
    localparam int NP = L / 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lift53_fwd_line_if #(.WIDTH(W), .LINE_LEN(L)) bus ();

    lift53_fwd_line #(.WIDTH(W), .LINE_LEN(L)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int s;
        int d;
        int idx;
        bit last;
    } pair_t;

    pair_t exp_q[$];
    pair_t mp;
    int    checks = 0;
    int    errors = 0;
    int    cur[L];
    int    ready_mode = 3;
    int    ready_phase = 0;
    int    err_pulses = 0;
    int    stalls = 0;
    int    base;
    bit    mon_en = 1'b0;
    bit    drv_bad = 1'b0;
    bit    err_pending = 1'b0;
    bit    held = 1'b0;
    logic signed [W+1:0] hs, hd;

    task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: whole-line lifting with explicit mirrored sample x[L] and d[-1] = d[0].
    task automatic push_line();
        int xe[L+1];
        int d[NP];
        int dm;
        pair_t p;
        for (int i = 0; i < L; i++) xe[i] = cur[i];
        xe[L] = cur[L-2];
        for (int n = 0; n < NP; n++)
            d[n] = xe[2*n+1] - ((xe[2*n] + xe[2*n+2]) >>> 1);
        for (int n = 0; n < NP; n++) begin
            dm     = (n == 0) ? d[0] : d[n-1];
            p.s    = xe[2*n] + ((dm + d[n] + 2) >>> 2);
            p.d    = d[n];
            p.idx  = n;
            p.last = (n == NP - 1);
            exp_q.push_back(p);
        end
    endtask

    task automatic send(input int v, input bit last, input bit bad, input bit gap);
        int n;
        bit acc;
        n   = 0;
        acc = 1'b0;
        if (gap) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        bus.in_valid = 1'b1;
        bus.in_data  = W'(v);
        bus.in_last  = last;
        drv_bad      = bad;
        while (!acc && n < 100) begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (n > 1) stalls++;
        if (!acc) check("accept_timeout", 0, 1);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        drv_bad      = 1'b0;
    endtask

    task automatic send_line(input int extra_last, input bit gap);
        bit last;
        for (int i = 0; i < L; i++) begin
            last = (i == L - 1) || (i == extra_last);
            send(cur[i], last, last != (i == L - 1), gap);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("idle_after_drain", bus.out_valid, 0);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: bus.out_ready = 1'b1;
            1: begin
                bus.out_ready = (ready_phase % 4 == 0) || (ready_phase % 4 == 3);
                ready_phase++;
            end
            2: bus.out_ready = ($urandom_range(0, 2) != 0);
            default: bus.out_ready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (mon_en) begin
            check("line_err", bus.line_err, err_pending);
            if (bus.line_err === 1'b1) err_pulses++;
            err_pending = bus.in_valid && bus.in_ready && drv_bad;
            check("in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
            if (held && bus.out_valid) begin
                check("hold_s", bus.out_s, hs);
                check("hold_d", bus.out_d, hd);
            end
            held = bus.out_valid && !bus.out_ready;
            hs   = bus.out_s;
            hd   = bus.out_d;
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pair", 1, 0);
                end else begin
                    mp = exp_q.pop_front();
                    check("out_s", bus.out_s, mp.s);
                    check("out_d", bus.out_d, mp.d);
                    check("out_idx", bus.out_idx, mp.idx);
                    check("out_last", bus.out_last, mp.last);
                end
            end
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_s", bus.out_s, 0);
        check("rst_out_d", bus.out_d, 0);
        check("rst_out_idx", bus.out_idx, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_line_err", bus.line_err, 0);
        @(posedge clk);
        #1;
        ready_mode = 0;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Directed reference line
        cur = '{164, 164, 164, 164, 156, 108, 200, 254};
        push_line();
        send_line(-1, 1'b0);
        drain();

        // Constant lines back to back: no input stall expected
        cur = '{100, 100, 100, 100, 100, 100, 100, 100};
        push_line();
        push_line();
        stalls = 0;
        send_line(-1, 1'b0);
        send_line(-1, 1'b0);
        drain();
        check("b2b_no_stall", stalls, 0);

        // Same reference line with out_ready pattern 1,0,0,1
        cur = '{164, 164, 164, 164, 156, 108, 200, 254};
        ready_phase = 0;
        ready_mode  = 1;
        push_line();
        send_line(-1, 1'b0);
        drain();

        // Extremes, both phases of alternation
        ready_mode = 0;
        for (int i = 0; i < L; i++) cur[i] = (i % 2 == 0) ? -512 : 511;
        push_line();
        send_line(-1, 1'b0);
        for (int i = 0; i < L; i++) cur[i] = (i % 2 == 0) ? 511 : -512;
        push_line();
        send_line(-1, 1'b0);
        drain();

        // Early in_last on x[5]: exactly one framing pulse, line still completes
        cur  = '{164, 164, 164, 164, 156, 108, 200, 254};
        base = err_pulses;
        push_line();
        send_line(5, 1'b0);
        drain();
        check("line_err_pulses", err_pulses - base, 1);

        // Reset mid-line, colliding with the acceptance of x[4]
        push_line();
        for (int i = 0; i < 4; i++) send(cur[i], 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.in_data  = W'(cur[4]);
        rst          = 1'b1;
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        exp_q.delete();
        held = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_out_s", bus.out_s, 0);
        check("midrst_out_d", bus.out_d, 0);
        check("midrst_out_idx", bus.out_idx, 0);
        check("midrst_out_last", bus.out_last, 0);
        @(posedge clk);
        #1;
        cur = '{-20, 37, 5, -300, 499, -512, 0, 77};
        push_line();
        send_line(-1, 1'b0);
        drain();

        // Randomized lines with random input gaps and output back-pressure
        ready_mode = 2;
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < L; i++) cur[i] = int'($urandom_range(0, 1023)) - 512;
            push_line();
            send_line(-1, 1'b1);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lift53_fwd_line.md
Name: lift53_fwd_line

Overview:
- Streaming, parametrised forward LeGall 5/3 lifting engine for one image line.
- Takes raw samples in order and emits one (s, d) coefficient pair per two input samples, with symmetric boundary extension at both line ends.
- Successor to the fixed-width single-point predict/update stage: configurable width and line length, plus valid/ready flow control and line framing.
- Sits between the line buffer and the subband writer in the DWT row pass.

Parameters:
- WIDTH, 10, signed two's-complement input sample width.
- LINE_LEN, 8, samples per line; must be even and >= 4. Elaboration fails otherwise.
- IDX_W, clog2(LINE_LEN/2), derived localparam, not overridable; width of the pair index.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample.
- in_data  in  WIDTH  signed input sample x[k].
- in_last  in  1  producer marks the final sample of a line; used only for checking.
- out_valid  out  1  output pair valid.
- out_ready  in  1  consumer accepts the pair.
- out_s  out  WIDTH+2  signed lowpass coefficient s[n].
- out_d  out  WIDTH+2  signed highpass coefficient d[n].
- out_idx  out  IDX_W  pair index n.
- out_last  out  1  n == LINE_LEN/2-1.
- line_err  out  1  one-cycle pulse on framing mismatch.

Behaviour:
- Reset: sync on rst. out_valid=0, out_s=0, out_d=0, out_idx=0, out_last=0, line_err=0, sample counter k=0, state=FIRST. A partially received line is discarded. Reset wins over any simultaneous handshake.
- Handshakes:
  - Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
  - in_ready = !out_valid || out_ready (combinational), so throughput is 1 sample/cycle with no bubbles.
  - Once asserted, out_valid and the output data hold stable until the pair is taken.
- Arithmetic (signed throughout):
  - d[n] = x[2n+1] - ((x[2n] + x[2n+2]) >>> 1).
  - s[n] = x[2n] + ((d[n-1] + d[n] + 2) >>> 2).
  - Arithmetic shifts give floor division.
  - Internal sums are WIDTH+3 bits. Results are stored at WIDTH+2 bits, which is lossless.
- Boundaries:
  - Right edge: x[LINE_LEN] = x[LINE_LEN-2], i.e. the last pair's d = x[L-1] - x[L-2].
  - Left edge: d[-1] = d[0].
- Storage: e (last even sample), o (last odd sample), dp (previous d).
- States:
  - FIRST: accept x[0] -> e=x; go to ODD.
  - ODD: accept x[2n+1] -> o=x.
    - If k == LINE_LEN-1: compute the final pair with the right-edge mirror, load the output register with out_last=1, then k=0 and go to FIRST.
    - Otherwise go to EVEN.
  - EVEN: accept x[2n+2] -> compute d[n] and s[n] (using dp, or d[n] itself when n==0), load the output register, dp=d[n], e=x; go to ODD.
- Latency: pair n is valid the cycle after acceptance of x[2n+2], or of x[L-1] for the last pair. Exactly LINE_LEN/2 pairs per line; out_idx increments 0..LINE_LEN/2-1.
- Framing check: line_err pulses the cycle after an accepted sample where in_last != (k == LINE_LEN-1). The data path is unaffected and counting continues.
- Back-to-back lines: x[0] of the next line may be accepted the cycle after x[L-1]. The first and last pairs use independent boundary terms, with no carry-over between lines.
- Output-register load and drain in the same cycle: the new pair overwrites and out_valid stays 1.

Test Plan:
- LINE_LEN=8, WIDTH=10, x = 164,164,164,164,156,108,200,254, out_ready=1 -> pairs (s,d) = (164,0), (165,4), (140,-70), (196,54); out_last only on idx 3; line_err never set.
- Constant line of eight samples of 100 -> every pair (100,0); two back-to-back lines give 8 pairs with no input stall.
- Same vector as the first scenario with out_ready toggled 1,0,0,1 repeatedly -> identical pair sequence; out_s/out_d stable while stalled; in_ready low exactly when out_valid && !out_ready.
- Negative extremes: x alternating -512, 511 -> d = 1023, s = -512 + ((1023+1023+2)>>>2) = 0 for n=0; no overflow at WIDTH+2.
- in_last asserted on x[5] -> single line_err pulse; the line still completes with 4 pairs.
- rst asserted after x[3] -> all outputs cleared next cycle; a fresh 8-sample line yields correct pairs starting at idx 0.
